pulse_sequencer: RTL
====================

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 Parameter MAX_DELAY_BITS, default 32, width of delay, width and timeout values.
REQ-002 Parameter DEPTH, default 8, number of sequence table entries (power of two, 2..16); IDX_BITS = log2(DEPTH).
REQ-003 clk  in  1  single clock (200 MHz); one clock domain; reset is synchronous and active-high.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 tbl_wr  in  1  table write strobe; tbl_addr in IDX_BITS; tbl_delay in MAX_DELAY_BITS; tbl_width in MAX_DELAY_BITS.
REQ-006 seq_len  in  IDX_BITS+1  number of pulses in sequence, sampled on accepted arm.
REQ-007 chain  in  1  sampled on arm: 1 = pulses after the first fire back-to-back without ext_trigger; 0 = each pulse waits for ext_trigger.
REQ-008 timeout_cycles  in  MAX_DELAY_BITS  per-pulse completion watchdog, sampled on arm; 0 disables.
REQ-009 arm  in  1  start request pulse; abort  in  1  cancel request pulse.
REQ-010 ext_trigger  in  1  single-cycle trigger pulse, already synchronised.
REQ-011 dly_delay_cycles, dly_width_cycles  out  MAX_DELAY_BITS  values for the delay unit; dly_delay_update, dly_width_update  out  1  load strobes.
REQ-012 dly_trigger  out  1  single-cycle trigger to the delay unit; dly_out  in  1  the delay unit's output pulse.
REQ-013 busy  out  1; armed  out  1; pulse_idx  out  IDX_BITS  current entry; done  out  1  pulse; fault  out  1  pulse.

Function
REQ-014 States: IDLE, LOAD, ARMED, FIRE, WAIT_HI, WAIT_LO.
REQ-015 tbl_wr writes entry tbl_addr only when state is IDLE; writes in any other state are ignored.
REQ-016 In IDLE, arm with 1 <= seq_len <= DEPTH: capture seq_len, chain, timeout_cycles; pulse_idx <= 0; go to LOAD. Arm with seq_len 0 or > DEPTH is ignored.
REQ-017 LOAD lasts exactly one cycle: drive entry pulse_idx on dly_delay_cycles/dly_width_cycles, assert both update strobes for that cycle; next state ARMED, except FIRE when chain=1 and pulse_idx != 0.
REQ-018 ARMED: armed=1; on ext_trigger go to FIRE; ext_trigger in any other state is ignored.
REQ-019 FIRE lasts one cycle: dly_trigger=1, watchdog loaded with timeout_cycles; next WAIT_HI.
REQ-020 dly_out is registered once internally; edge detection uses registered value and its previous value.
REQ-021 WAIT_HI: on rising edge of registered dly_out go to WAIT_LO. WAIT_LO: on falling edge, pulse completes.
REQ-022 On completion: if pulse_idx = seq_len-1, assert done one cycle and go IDLE; else pulse_idx increments and go LOAD.
REQ-023 Watchdog decrements every cycle in WAIT_HI and WAIT_LO when enabled; reaching 0 asserts fault one cycle, go IDLE, done not asserted.
REQ-024 abort in any non-IDLE state: next cycle IDLE, no done, no fault, no strobes; abort and arm in the same cycle: abort wins, arm dropped.
REQ-025 busy = 1 in every state except IDLE; dly_trigger, update strobes, done, fault are each high for exactly one cycle per event.
REQ-026 dly_delay_cycles/dly_width_cycles hold last loaded values between LOAD cycles.
REQ-027 Table entry values pass unmodified; width 0 is forwarded as 0 (delay unit treats it as 1).

Reset
REQ-028 rst forces IDLE from any state, including mid-sequence, with no done/fault pulse.
REQ-029 Reset values: all outputs 0; pulse_idx 0; captured seq_len 0, chain 0, timeout 0; watchdog 0.
REQ-030 rst initialises every table entry to delay 0, width 1.

Verification
REQ-031 Write entry0 = (delay 10, width 3), seq_len 1, chain 0, arm, ext_trigger -> one update cycle with 10/3, dly_trigger 1 cycle after ext_trigger, done 1 cycle after registered dly_out falls.
REQ-032 Entries (5,2),(20,4),(0,1), seq_len 3, chain 1, one ext_trigger -> three LOAD/FIRE pairs, pulse_idx 0,1,2, single done; second ext_trigger during sequence ignored.
REQ-033 seq_len 2, chain 0 -> after first pulse armed=1 again, second pulse fires only on second ext_trigger.
REQ-034 timeout_cycles 50, dly_out held 0 -> fault exactly 50 cycles after FIRE cycle, busy drops, done never asserted.
REQ-035 abort asserted in WAIT_LO, and separately rst asserted in ARMED -> IDLE next cycle, no done/fault; tbl_wr while busy leaves table unchanged.
REQ-036 arm with seq_len 0 and with seq_len DEPTH+1 -> remains IDLE, busy stays 0.

Source files
------------

// File: rtl/pulse_sequencer.sv
// Table-driven pulse sequencer: steps through a table of (delay, width) entries,
// loads each into an external delay unit, fires it, and tracks its output pulse.
module pulse_sequencer #(
  parameter int MAX_DELAY_BITS = 32,
  parameter int DEPTH          = 8,
  localparam int IDX_BITS      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tbl_wr,
  input  logic [IDX_BITS-1:0]       tbl_addr,
  input  logic [MAX_DELAY_BITS-1:0] tbl_delay,
  input  logic [MAX_DELAY_BITS-1:0] tbl_width,
  input  logic [IDX_BITS:0]         seq_len,
  input  logic                      chain,
  input  logic [MAX_DELAY_BITS-1:0] timeout_cycles,
  input  logic                      arm,
  input  logic                      abort,
  input  logic                      ext_trigger,
  output logic [MAX_DELAY_BITS-1:0] dly_delay_cycles,
  output logic [MAX_DELAY_BITS-1:0] dly_width_cycles,
  output logic                      dly_delay_update,
  output logic                      dly_width_update,
  output logic                      dly_trigger,
  input  logic                      dly_out,
  output logic                      busy,
  output logic                      armed,
  output logic [IDX_BITS-1:0]       pulse_idx,
  output logic                      done,
  output logic                      fault
);

  typedef enum logic [2:0] {IDLE, LOAD, ARMED, FIRE, WAIT_HI, WAIT_LO} state_t;

  localparam logic [IDX_BITS:0]         LEN_ONE = {{IDX_BITS{1'b0}}, 1'b1};
  localparam logic [IDX_BITS:0]         LEN_MAX = DEPTH[IDX_BITS:0];
  localparam logic [IDX_BITS-1:0]       IDX_ONE = {{(IDX_BITS-1){1'b0}}, 1'b1};
  localparam logic [MAX_DELAY_BITS-1:0] WD_ONE  = {{(MAX_DELAY_BITS-1){1'b0}}, 1'b1};

  state_t                    state, state_nx;
  logic [MAX_DELAY_BITS-1:0] tbl_dly [DEPTH];
  logic [MAX_DELAY_BITS-1:0] tbl_wid [DEPTH];
  logic [IDX_BITS:0]         seq_len_q, last_idx;
  logic                      chain_q;
  logic [MAX_DELAY_BITS-1:0] timeout_q, wdog, delay_q, width_q;
  logic                      dly_q, dly_prev;
  logic                      rise, fall, last, wd_expire, len_ok, kill;
  logic                      complete, expire;

  assign rise      = dly_q & ~dly_prev;
  assign fall      = ~dly_q & dly_prev;
  assign last_idx  = seq_len_q - LEN_ONE;
  assign last      = ({1'b0, pulse_idx} == last_idx);
  assign wd_expire = (timeout_q != '0) && (wdog == WD_ONE);
  assign len_ok    = (seq_len != '0) && (seq_len <= LEN_MAX);
  assign kill      = abort | rst;

  always_comb begin
    state_nx = state;
    complete = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE:    if (arm && !abort && len_ok) state_nx = LOAD;
      LOAD:    state_nx = (chain_q && pulse_idx != '0) ? FIRE : ARMED;
      ARMED:   if (ext_trigger) state_nx = FIRE;
      FIRE:    state_nx = WAIT_HI;
      WAIT_HI: begin
        if (rise) state_nx = WAIT_LO;
        else if (wd_expire) begin
          expire   = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT_LO: begin
        if (fall) begin
          complete = 1'b1;
          state_nx = last ? IDLE : LOAD;
        end else if (wd_expire) begin
          expire   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Abort beats everything, including a completion or expiry in the same cycle.
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      complete = 1'b0;
      expire   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pulse_idx <= '0;
      seq_len_q <= '0;
      chain_q   <= 1'b0;
      timeout_q <= '0;
      wdog      <= '0;
      dly_q     <= 1'b0;
      dly_prev  <= 1'b0;
      delay_q   <= '0;
      width_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_dly[i] <= '0;
        tbl_wid[i] <= WD_ONE;
      end
    end else begin
      state    <= state_nx;
      dly_q    <= dly_out;
      dly_prev <= dly_q;
      if (state == IDLE && tbl_wr) begin
        tbl_dly[tbl_addr] <= tbl_delay;
        tbl_wid[tbl_addr] <= tbl_width;
      end
      if (state == IDLE && state_nx == LOAD) begin
        seq_len_q <= seq_len;
        chain_q   <= chain;
        timeout_q <= timeout_cycles;
        pulse_idx <= '0;
      end
      if (state == LOAD && !abort) begin
        delay_q <= tbl_dly[pulse_idx];
        width_q <= tbl_wid[pulse_idx];
      end
      if (state == FIRE) wdog <= timeout_q;
      else if ((state == WAIT_HI || state == WAIT_LO) && timeout_q != '0 && wdog != '0)
        wdog <= wdog - WD_ONE;
      if (state == WAIT_LO && state_nx == LOAD) pulse_idx <= pulse_idx + IDX_ONE;
    end
  end

  // During LOAD the entry is forwarded straight from the table; afterwards it is held.
  assign dly_delay_cycles = (state == LOAD) ? tbl_dly[pulse_idx] : delay_q;
  assign dly_width_cycles = (state == LOAD) ? tbl_wid[pulse_idx] : width_q;
  assign dly_delay_update = (state == LOAD) && !kill;
  assign dly_width_update = (state == LOAD) && !kill;
  assign dly_trigger      = (state == FIRE) && !kill;
  assign busy             = (state != IDLE);
  assign armed            = (state == ARMED);
  assign done             = complete && last && !rst;
  assign fault            = expire && !rst;

endmodule
